// File: rtl/rgmii_rx_ctrl.sv
// -----------------------------------------------------------------------------
// rgmii_rx_ctrl
//   Receive-side controller behind the RGMII input DDR stage. It rebuilds
//   bytes from rising/falling nibble pairs, strips preamble and SFD, and emits
//   each frame as a byte stream with no backpressure and with last/error
//   marking. It also captures in-band link status from inter-frame idle bytes
//   and keeps saturating frame and error counters.
//
// Ports
//   phy_clk        in   RGMII rx clock, shared with the IDDR stage
//   phy_rst_n      in   asynchronous active-low reset
//   rxd_q1/_q2     in   rising-edge (low) / falling-edge (high) data nibbles
//   rxctl_q1/_q2   in   RX_DV / RX_DV^RX_ER
//   m_axis_*       out  frame byte stream: tdata, tvalid, tlast, tuser (bad frame)
//   link_*         out  in-band link status: up, speed (00/01/10), duplex
//   frame_cnt      out  frames ended with tlast (saturating)
//   err_cnt        out  bad frames plus preamble/SFD/zero-length aborts (saturating)
// -----------------------------------------------------------------------------
module rgmii_rx_ctrl #(
  parameter int MIN_PREAMBLE = 1,
  parameter int MAX_FRAME    = 1522,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 phy_clk,
  input  logic                 phy_rst_n,
  input  logic [3:0]           rxd_q1,
  input  logic [3:0]           rxd_q2,
  input  logic                 rxctl_q1,
  input  logic                 rxctl_q2,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 link_up,
  output logic [1:0]           link_speed,
  output logic                 link_duplex,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam int PRE_W = (MIN_PREAMBLE < 1) ? 1 : $clog2(MIN_PREAMBLE + 1);
  localparam int LEN_W = $clog2(MAX_FRAME + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_DATA, ST_DROP} state_t;

  state_t             r_state, w_state_nxt;

  // S1 capture of the DDR pair
  logic [7:0]         r_s1_byte;
  logic               r_s1_dv, r_s1_er;

  // One-byte hold register: a byte is only emitted once we know whether it is last
  logic [7:0]         r_hold,    w_hold_nxt;
  logic               r_held,    w_held_nxt;
  logic               r_bad,     w_bad_nxt;
  logic [LEN_W-1:0]   r_len,     w_len_nxt;
  logic [PRE_W-1:0]   r_pre_cnt, w_pre_nxt;

  logic               w_beat, w_last, w_user, w_err_inc;

  logic [7:0]         r_tdata;
  logic               r_tvalid, r_tlast, r_tuser;
  logic               r_link_up, r_link_duplex;
  logic [1:0]         r_link_speed;
  logic [CNT_WIDTH-1:0] r_frame_cnt, r_err_cnt;

  logic               w_is_pre, w_is_sfd, w_pre_ok, w_len_full;

  assign w_is_pre   = (r_s1_byte == 8'h55);
  assign w_is_sfd   = (r_s1_byte == 8'hD5);
  assign w_pre_ok   = (r_pre_cnt >= PRE_W'(MIN_PREAMBLE));
  assign w_len_full = (r_len == LEN_W'(MAX_FRAME));

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge phy_clk or negedge phy_rst_n) begin
    if (!phy_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:     if (r_s1_dv) w_state_nxt = w_is_pre ? ST_PREAMBLE : ST_DROP;
      ST_PREAMBLE: begin
        if (!r_s1_dv)                  w_state_nxt = ST_IDLE;
        else if (w_is_pre)             w_state_nxt = ST_PREAMBLE;
        else if (w_is_sfd && w_pre_ok) w_state_nxt = ST_DATA;
        else                           w_state_nxt = ST_DROP;
      end
      ST_DATA: begin
        if (!r_s1_dv)        w_state_nxt = ST_IDLE;
        else if (w_len_full) w_state_nxt = ST_DROP;  // byte MAX_FRAME+1 truncates
      end
      ST_DROP:     if (!r_s1_dv) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath-control logic
  always_comb begin
    w_beat     = 1'b0;
    w_last     = 1'b0;
    w_user     = 1'b0;
    w_err_inc  = 1'b0;
    w_hold_nxt = r_hold;
    w_held_nxt = r_held;
    w_bad_nxt  = r_bad;
    w_len_nxt  = r_len;
    w_pre_nxt  = r_pre_cnt;
    unique case (r_state)
      ST_IDLE: begin
        w_held_nxt = 1'b0;
        w_bad_nxt  = 1'b0;
        w_len_nxt  = '0;
        if (r_s1_dv) begin
          if (w_is_pre) w_pre_nxt = PRE_W'(1);
          else          w_err_inc = 1'b1;
        end
      end
      ST_PREAMBLE: begin
        if (!r_s1_dv)                     w_err_inc = 1'b1;
        else if (w_is_pre) begin
          if (!w_pre_ok)                  w_pre_nxt = r_pre_cnt + 1'b1;
        end
        else if (!(w_is_sfd && w_pre_ok)) w_err_inc = 1'b1;
      end
      ST_DATA: begin
        if (!r_s1_dv) begin
          // End of frame: flush the held byte as last, or flag an empty frame
          w_held_nxt = 1'b0;
          if (r_held) begin
            w_beat    = 1'b1;
            w_last    = 1'b1;
            w_user    = r_bad;
            w_err_inc = r_bad;
          end else begin
            w_err_inc = 1'b1;
          end
        end else if (w_len_full) begin
          // Overlength: drop the new byte, close the frame as bad
          w_held_nxt = 1'b0;
          w_beat     = 1'b1;
          w_last     = 1'b1;
          w_user     = 1'b1;
          w_err_inc  = 1'b1;
        end else begin
          w_beat     = r_held;
          w_hold_nxt = r_s1_byte;
          w_held_nxt = 1'b1;
          w_bad_nxt  = r_bad | r_s1_er;
          w_len_nxt  = r_len + 1'b1;
        end
      end
      ST_DROP: ;
      default: ;
    endcase
  end

  // Datapath, stream, status and counter registers
  // NOTE: no memories here; every flop, hold register included, takes the async reset.
  always_ff @(posedge phy_clk or negedge phy_rst_n) begin
    if (!phy_rst_n) begin
      r_s1_byte     <= '0;
      r_s1_dv       <= 1'b0;
      r_s1_er       <= 1'b0;
      r_hold        <= '0;
      r_held        <= 1'b0;
      r_bad         <= 1'b0;
      r_len         <= '0;
      r_pre_cnt     <= '0;
      r_tdata       <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_tuser       <= 1'b0;
      r_link_up     <= 1'b0;
      r_link_speed  <= '0;
      r_link_duplex <= 1'b0;
      r_frame_cnt   <= '0;
      r_err_cnt     <= '0;
    end else begin
      r_s1_byte <= {rxd_q2, rxd_q1};
      r_s1_dv   <= rxctl_q1;
      r_s1_er   <= rxctl_q1 ^ rxctl_q2;
      r_hold    <= w_hold_nxt;
      r_held    <= w_held_nxt;
      r_bad     <= w_bad_nxt;
      r_len     <= w_len_nxt;
      r_pre_cnt <= w_pre_nxt;
      r_tvalid  <= w_beat;
      r_tlast   <= w_last;
      r_tuser   <= w_user;
      r_tdata   <= w_beat ? r_hold : 8'h00;
      // Inter-frame idle bytes carry link status
      if (!r_s1_dv && !r_s1_er) begin
        r_link_up     <= r_s1_byte[0];
        r_link_speed  <= r_s1_byte[2:1];
        r_link_duplex <= r_s1_byte[3];
      end
      if (w_last && !(&r_frame_cnt))  r_frame_cnt <= r_frame_cnt + 1'b1;
      if (w_err_inc && !(&r_err_cnt)) r_err_cnt   <= r_err_cnt + 1'b1;
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign link_up       = r_link_up;
  assign link_speed    = r_link_speed;
  assign link_duplex   = r_link_duplex;
  assign frame_cnt     = r_frame_cnt;
  assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_rgmii_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rgmii_rx_ctrl
//   Drives two instances from one RGMII stimulus stream: A with default
//   parameters, B with MIN_PREAMBLE=2, MAX_FRAME=16, CNT_WIDTH=2. A frame-level
//   reference model splits the stream into dv runs, parses each run as
//   preamble/SFD/payload and predicts beats (with cycle), counters and link.
// -----------------------------------------------------------------------------
module tb_rgmii_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rxd_q1 = '0, rxd_q2 = '0;
  logic       rxctl_q1 = 1'b0, rxctl_q2 = 1'b0;

  logic [7:0]  a_tdata, b_tdata;
  logic        a_tvalid, a_tlast, a_tuser, b_tvalid, b_tlast, b_tuser;
  logic        a_link_up, a_link_duplex, b_link_up, b_link_duplex;
  logic [1:0]  a_link_speed, b_link_speed;
  logic [15:0] a_frame_cnt, a_err_cnt;
  logic [1:0]  b_frame_cnt, b_err_cnt;

  always #5 clk = ~clk;

  rgmii_rx_ctrl u_dut_a (
    .phy_clk(clk), .phy_rst_n(rst_n),
    .rxd_q1(rxd_q1), .rxd_q2(rxd_q2), .rxctl_q1(rxctl_q1), .rxctl_q2(rxctl_q2),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tlast(a_tlast),
    .m_axis_tuser(a_tuser), .link_up(a_link_up), .link_speed(a_link_speed),
    .link_duplex(a_link_duplex), .frame_cnt(a_frame_cnt), .err_cnt(a_err_cnt)
  );

  rgmii_rx_ctrl #(.MIN_PREAMBLE(2), .MAX_FRAME(16), .CNT_WIDTH(2)) u_dut_b (
    .phy_clk(clk), .phy_rst_n(rst_n),
    .rxd_q1(rxd_q1), .rxd_q2(rxd_q2), .rxctl_q1(rxctl_q1), .rxctl_q2(rxctl_q2),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tlast(b_tlast),
    .m_axis_tuser(b_tuser), .link_up(b_link_up), .link_speed(b_link_speed),
    .link_duplex(b_link_duplex), .frame_cnt(b_frame_cnt), .err_cnt(b_err_cnt)
  );

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  typedef struct {
    logic [7:0] b;
    logic       dv;
    logic       er;
    int         e;     // clock edge at which the input stage samples it
  } rec_t;

  beat_t obs_a[$], obs_b[$], exp_a[$], exp_b[$];
  rec_t  stim[$];
  int    cyc = 0;
  int    n_checks = 0, n_pass = 0;
  int    exp_frames[2], exp_errs[2];
  logic [7:0] exp_lnk;
  logic [7:0] lnk_byte;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_tvalid) obs_a.push_back('{cyc, a_tdata, a_tlast, a_tuser});
      if (b_tvalid) obs_b.push_back('{cyc, b_tdata, b_tlast, b_tuser});
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int sat(input int v, input int w);
    return (v > (2**w - 1)) ? (2**w - 1) : v;
  endfunction

  // ---- stimulus builders ----
  task automatic add_rec(input logic [7:0] b, input logic dv, input logic er);
    stim.push_back('{b, dv, er, 0});
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) add_rec(lnk_byte, 1'b0, 1'b0);
  endtask

  // pre x 0x55, then SFD (or a wrong byte), then len payload bytes
  task automatic add_frame(input int pre, input logic sfd_ok, input int len,
                           input logic seq, input int er_pos, input int er_pct);
    logic [7:0] x;
    for (int i = 0; i < pre; i++) add_rec(8'h55, 1'b1, ($urandom_range(0, 99) < er_pct));
    if (sfd_ok) add_rec(8'hD5, 1'b1, 1'b0);
    else begin
      do x = 8'($urandom); while (x == 8'h55 || x == 8'hD5);
      add_rec(x, 1'b1, 1'b0);
    end
    for (int i = 0; i < len; i++) begin
      x = seq ? 8'(i + 1) : 8'($urandom);
      add_rec(x, 1'b1, (i == er_pos) || ($urandom_range(0, 99) < er_pct));
    end
  endtask

  task automatic drive_stim();
    for (int i = 0; i < stim.size(); i++) begin
      @(negedge clk);
      rxd_q1   = stim[i].b[3:0];
      rxd_q2   = stim[i].b[7:4];
      rxctl_q1 = stim[i].dv;
      rxctl_q2 = stim[i].dv ^ stim[i].er;
      stim[i].e = cyc + 1;
    end
  endtask

  // ---- reference model: frame grammar over dv runs ----
  task automatic model_run(input int d, input int min_pre, input int max_frame);
    int i, j, p, s, len, lim;
    logic bad;
    beat_t bt;
    i = 0;
    while (i < stim.size()) begin
      if (!stim[i].dv) begin
        if (!stim[i].er) exp_lnk = stim[i].b;
        i++;
      end else begin
        j = i;
        while (j < stim.size() && stim[j].dv) j++;
        p = 0;
        while (i + p < j && stim[i + p].b == 8'h55) p++;
        if (p == 0 || i + p == j || stim[i + p].b != 8'hD5 || p < min_pre) begin
          exp_errs[d]++;
        end else begin
          s   = i + p + 1;
          len = j - s;
          if (len == 0) exp_errs[d]++;
          else begin
            lim = (len > max_frame) ? max_frame : len;
            bad = (len > max_frame);
            for (int k = 0; k < lim; k++) bad |= stim[s + k].er;
            for (int k = 0; k < lim; k++) begin
              bt.cyc  = stim[s + k].e + 2;
              bt.data = stim[s + k].b;
              bt.last = (k == lim - 1);
              bt.user = (k == lim - 1) && bad;
              if (d == 0) exp_a.push_back(bt); else exp_b.push_back(bt);
            end
            exp_frames[d]++;
            if (bad) exp_errs[d]++;
          end
        end
        i = j;
      end
    end
  endtask

  task automatic cmp_beats(input string tag, input beat_t o[$], input beat_t e[$]);
    check({tag, "_beats"}, 64'(o.size()), 64'(e.size()));
    for (int k = 0; k < o.size() && k < e.size(); k++)
      check($sformatf("%s_beat%0d", tag, k),
            {o[k].cyc, o[k].data, o[k].last, o[k].user},
            {e[k].cyc, e[k].data, e[k].last, e[k].user});
  endtask

  task automatic run_scen(input string tag);
    add_idle(4);
    drive_stim();
    repeat (2) @(negedge clk);
    model_run(0, 1, 1522);
    model_run(1, 2, 16);
    cmp_beats({tag, "_a"}, obs_a, exp_a);
    cmp_beats({tag, "_b"}, obs_b, exp_b);
    check({tag, "_a_frame_cnt"}, 64'(a_frame_cnt), 64'(sat(exp_frames[0], 16)));
    check({tag, "_a_err_cnt"},   64'(a_err_cnt),   64'(sat(exp_errs[0], 16)));
    check({tag, "_b_frame_cnt"}, 64'(b_frame_cnt), 64'(sat(exp_frames[1], 2)));
    check({tag, "_b_err_cnt"},   64'(b_err_cnt),   64'(sat(exp_errs[1], 2)));
    check({tag, "_a_link"}, 64'({a_link_duplex, a_link_speed, a_link_up}), 64'(exp_lnk[3:0]));
    check({tag, "_b_link"}, 64'({b_link_duplex, b_link_speed, b_link_up}), 64'(exp_lnk[3:0]));
    stim.delete(); obs_a.delete(); obs_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  task automatic clear_model();
    exp_frames[0] = 0; exp_frames[1] = 0;
    exp_errs[0]   = 0; exp_errs[1]   = 0;
    exp_lnk = 8'h00;
    stim.delete(); obs_a.delete(); obs_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_out"}, 64'({a_tdata, a_tvalid, a_tlast, a_tuser, a_link_up, a_link_speed,
                                a_link_duplex, a_frame_cnt, a_err_cnt}), 64'd0);
    check({tag, "_b_out"}, 64'({b_tdata, b_tvalid, b_tlast, b_tuser, b_link_up, b_link_speed,
                                b_link_duplex, b_frame_cnt, b_err_cnt}), 64'd0);
  endtask

  initial begin
    clear_model();
    lnk_byte = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #2 rst_n = 1'b1;

    // Link status from idle D/D, then a good 64-byte frame (B truncates it)
    lnk_byte = 8'hDD;
    add_idle(5);
    add_frame(7, 1'b1, 64, 1'b1, -1, 0);
    run_scen("good64");
    check("link_up_dd",     64'(a_link_up),     64'd1);
    check("link_speed_dd",  64'(a_link_speed),  64'd2);
    check("link_duplex_dd", 64'(a_link_duplex), 64'd1);

    // RX_ER on data byte 10
    add_frame(7, 1'b1, 64, 1'b1, 9, 0);
    run_scen("rxer");

    // Preamble abort, short-preamble SFD, zero-length frame, bad SFD, no preamble
    add_frame(3, 1'b1, 0, 1'b1, -1, 0);
    stim.pop_back();                       // drop the SFD: 3x55 then dv drop
    add_idle(2);
    add_frame(1, 1'b1, 8, 1'b1, -1, 0);    // 55,D5,...: good on A, early SFD on B
    add_idle(2);
    add_frame(2, 1'b1, 0, 1'b1, -1, 0);    // zero-length frame
    add_idle(2);
    add_frame(4, 1'b0, 5, 1'b0, -1, 0);    // wrong SFD byte
    add_idle(2);
    add_frame(0, 1'b0, 3, 1'b0, -1, 0);    // no preamble at all
    run_scen("aborts");

    // Length boundaries around MAX_FRAME=16 on B, then a normal frame
    add_frame(7, 1'b1, 16, 1'b1, -1, 0);
    add_idle(2);
    add_frame(7, 1'b1, 17, 1'b1, -1, 0);
    add_idle(2);
    add_frame(7, 1'b1, 20, 1'b1, -1, 0);
    add_idle(2);
    add_frame(7, 1'b1, 10, 1'b0, -1, 0);
    run_scen("maxlen");

    // Randomized frames, gaps with random status and occasional RX_ER idles
    for (int g = 0; g < 6; g++) begin
      for (int f = 0; f < 5; f++) begin
        add_frame($urandom_range(0, 8), ($urandom_range(0, 9) != 0), $urandom_range(0, 30),
                  1'b0, -1, ($urandom_range(0, 2) == 0) ? 5 : 0);
        lnk_byte = 8'($urandom);
        add_idle($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 1) add_rec(8'($urandom), 1'b0, 1'b1);
        add_idle(1);
      end
      run_scen($sformatf("rand%0d", g));
    end

    // Reset in the middle of a frame, then the rest of the burst and a good frame
    add_frame(7, 1'b1, 5, 1'b1, -1, 0);
    drive_stim();
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    clear_model();
    @(posedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) add_rec(8'(i + 6), 1'b1, 1'b0);
    run_scen("after_reset");
    add_frame(7, 1'b1, 12, 1'b1, -1, 0);
    run_scen("post_reset_good");

    // Counter saturation on B (2-bit): five more good frames
    for (int f = 0; f < 5; f++) begin
      add_frame(7, 1'b1, 8, 1'b0, -1, 0);
      add_idle(2);
    end
    run_scen("saturate");
    check("b_frame_cnt_sat", 64'(b_frame_cnt), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
